// File: rtl/arith_pkg.sv
// Shared opcode/state types for the sequential ALU.
// ARITH_SAT_EN (consumers) switches ADD/SUB/MUL to unsigned saturation.
package arith_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_FLP = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_MUL = 4'd8,
    OP_EQL = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_iter(op_e o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_MUL);
  endfunction

endpackage

// File: rtl/arith_iter.sv
// Iterative shift / shift-add multiply datapath: one step per cycle, `last` flags the final step.
// No backpressure of its own; the FSM drives start/step. ARITH_SAT_EN clamps MUL overflow.
module arith_iter
  import arith_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               step,
  input  op_e                mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   res_nxt,
  output logic               carry_nxt,
  output logic               last
);

  localparam int CNT_W = SHAMT_W + 1;

  logic [2*WIDTH-1:0] p_q, p_d, p_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                mode_q, mode_d;
  logic [WIDTH:0]     sum;
  logic               c_step;

  // Multiply keeps {partial product, remaining multiplier} in p; shifts use its low half.
  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    p_step = p_q;
    c_step = 1'b0;
    case (mode_q)
      OP_SHL: begin
        p_step = {{WIDTH{1'b0}}, p_q[WIDTH-2:0], 1'b0};
        c_step = p_q[WIDTH-1];
      end
      OP_SHR: begin
        p_step = {{(WIDTH+1){1'b0}}, p_q[WIDTH-1:1]};
        c_step = p_q[0];
      end
      OP_MUL: begin
        p_step = p_q[0] ? {sum, p_q[WIDTH-1:1]} : {1'b0, p_q[2*WIDTH-1:1]};
        c_step = |p_step[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  always_comb begin
    p_d     = p_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (start) begin
      mode_d  = mode;
      mcand_d = a;
      p_d     = {{WIDTH{1'b0}}, (mode == OP_MUL) ? b : a};
      cnt_d   = (mode == OP_MUL) ? CNT_W'(WIDTH) : {1'b0, shamt};
    end else if (step && (cnt_q != '0)) begin
      p_d   = p_step;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    res_nxt = p_step[WIDTH-1:0];
`ifdef ARITH_SAT_EN
    if ((mode_q == OP_MUL) && c_step) res_nxt = '1;
`endif
  end

  assign carry_nxt = c_step;
  assign last      = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q     <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      mode_q  <= OP_ADD;
    end else begin
      p_q     <= p_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: rtl/arith_unit_seq.sv
// Multi-cycle ALU: 1 cycle for simple ops, shamt/WIDTH EXEC cycles for shifts/MUL; result held until out_ready.
// in_ready only in IDLE (no acceptance while busy or holding a result). ARITH_SAT_EN enables saturation.
module arith_unit_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             f_carry,
  output logic             f_zero,
  output logic             f_neg,
  output logic             f_eq,
  output logic             err
);

  localparam int SHAMT_W = $clog2(WIDTH);

  op_e              op_in;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
  logic             eq_q, eq_d, err_q, err_d;
  logic             go_exec, accept;
  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] alu_res, it_res;
  logic             alu_c, alu_err, it_start, it_step, it_last, it_carry;

  assign op_in   = op_e'(op);
  // A zero-length shift is just a copy, so it takes the single-cycle path.
  assign go_exec = is_iter(op_in) &&
                   !(((op_in == OP_SHL) || (op_in == OP_SHR)) && (y[SHAMT_W-1:0] == '0));
  assign accept  = (state_q == S_IDLE) && in_valid;

  always_comb begin
    sum_add = {1'b0, x} + {1'b0, y};
    sum_sub = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (op_in)
      OP_ADD: begin
        alu_res = sum_add[WIDTH-1:0];
        alu_c   = sum_add[WIDTH];
`ifdef ARITH_SAT_EN
        if (alu_c) alu_res = '1;
`endif
      end
      OP_SUB: begin
        alu_res = sum_sub[WIDTH-1:0];
        alu_c   = sum_sub[WIDTH];
`ifdef ARITH_SAT_EN
        if (!alu_c) alu_res = '0;
`endif
      end
      OP_AND:         alu_res = x & y;
      OP_OR:          alu_res = x | y;
      OP_XOR:         alu_res = x ^ y;
      OP_FLP:         alu_res = ~x;
      OP_SHL, OP_SHR: alu_res = x;
      OP_MUL:         alu_res = '0;
      OP_EQL:         alu_res = {{(WIDTH-1){1'b0}}, (x == y)};
      default:        alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = go_exec ? S_EXEC : S_DONE;
      S_EXEC:  if (it_last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    it_start  = accept && go_exec;
    it_step   = (state_q == S_EXEC);
  end

  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    eq_d    = eq_q;
    err_d   = err_q;
    if (accept && !go_exec) begin
      res_d   = alu_res;
      carry_d = alu_c;
      err_d   = alu_err;
      eq_d    = !alu_err && (x == y);
      zero_d  = !alu_err && (alu_res == '0);
      neg_d   = alu_res[WIDTH-1];
    end else if (accept) begin
      eq_d  = (x == y);
      err_d = 1'b0;
    end else if (it_step && it_last) begin
      res_d   = it_res;
      carry_d = it_carry;
      zero_d  = (it_res == '0);
      neg_d   = it_res[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      eq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      eq_q    <= eq_d;
      err_q   <= err_d;
    end
  end

  arith_iter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (it_start),
    .step      (it_step),
    .mode      (op_in),
    .a         (x),
    .b         (y),
    .shamt     (y[SHAMT_W-1:0]),
    .res_nxt   (it_res),
    .carry_nxt (it_carry),
    .last      (it_last)
  );

  assign res     = res_q;
  assign f_carry = carry_q;
  assign f_zero  = zero_q;
  assign f_neg   = neg_q;
  assign f_eq    = eq_q;
  assign err     = err_q;

endmodule

// File: doc/arith_unit_seq.md
Name: arith_unit_seq

Overview:
- Parametrised, multi-cycle successor to the combinational CPU ALU.
- Accepts one operation per transaction through a valid/ready input handshake and returns the result, status flags and an error bit through a registered valid/ready output stage.
- Single-cycle ops (add/sub/logic/compare) and iterative ops (variable shifts, shift-add multiply) share one FSM.
- Sits between decode and register writeback; it stalls the pipeline via in_ready.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4). Derived SHAMT_W = $clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept an operation this cycle
- op  in  4  opcode (arith_pkg::op_e)
- x  in  WIDTH  operand A
- y  in  WIDTH  operand B; its low SHAMT_W bits are the shift amount for shifts
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- res  out  WIDTH  result
- f_carry  out  1  carry / no-borrow / shifted-out bit / multiply overflow
- f_zero  out  1  res == 0
- f_neg  out  1  res[WIDTH-1]
- f_eq  out  1  x == y (latched operands)
- err  out  1  illegal opcode

Behaviour:
- Reset (asynchronous, active-high): state IDLE, in_ready=1 once released, out_valid=0, res=0, all flags=0, err=0, internal counters and operands cleared. Reset mid-EXEC or mid-DONE aborts the operation with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch op/x/y. Single-cycle op -> DONE (result registered that edge, 1-cycle latency). Iterative op -> EXEC.
  - EXEC: in_ready=0. Performs one step per cycle.
    - SHL/SHR: shift by 1 per cycle, cnt = y[SHAMT_W-1:0]. Shift amount 0 goes straight to DONE with res=x, carry=0.
    - MUL: shift-add, exactly WIDTH cycles.
    - -> DONE when cnt reaches 0.
  - DONE: out_valid=1, in_ready=0. Outputs hold stable until out_ready=1, then -> IDLE. No back-to-back acceptance in DONE: max throughput is one op per 2 cycles for single-cycle ops.
- Ops, all arithmetic modulo 2^WIDTH:
  - ADD: carry = bit WIDTH of the sum.
  - SUB: x + ~y + 1; carry = 1 means no borrow.
  - AND, OR, XOR: carry = 0.
  - FLP: ~x; carry = 0.
  - SHL/SHR: logical shifts; carry = last bit shifted out.
  - MUL: res = low WIDTH bits; carry = 1 if the high half is nonzero.
  - EQL: res = {WIDTH-1'b0, x==y}.
- f_eq is computed for every op. f_zero and f_neg are computed from the final res.
- Illegal opcode: 1-cycle path to DONE, res=0, flags=0, err=1.
- in_valid while in_ready=0 is ignored; the source must hold it. Operands are latched, so input changes after acceptance have no effect.

Optional Feature:
- ARITH_SAT_EN defined: ADD/SUB saturate unsigned. ADD clamps to all-ones when carry=1. SUB clamps to 0 on borrow. MUL clamps to all-ones on overflow. Carry still reports the raw overflow condition.
- Undefined: wrap-around as specified above; the saturation logic is absent.

Decomposition:
- arith_pkg: op_e enum (ADD, SUB, AND, OR, XOR, FLP, SHL, SHR, MUL, EQL; remaining codes illegal), state_e enum (IDLE, EXEC, DONE), function is_iter(op_e).
- Sub-module arith_iter: the shift/multiply datapath with accumulator, counter, step and done signals. The FSM and single-cycle ops stay in arith_unit_seq.

Test Plan (WIDTH=8):
- ADD x=165, y=8'hFF -> res=164, f_carry=1, out_valid exactly 1 cycle after acceptance. SUB 77-27 -> 50, carry=1. AND 8'hFC & 8'h3F -> 8'h3C.
- SHL x=8'h81, y=3 -> 3 EXEC cycles, res=8'h08, carry=0. SHR x=8'h81, y=1 -> res=8'h40, carry=1. Shift by 0 -> res=x.
- MUL 13*12 -> 8 EXEC cycles, res=156, carry=0. MUL 16*16 -> res=0, f_zero=1, carry=1. Repeat with ARITH_SAT_EN -> res=8'hFF.
- Backpressure: out_ready=0 for 5 cycles after a result -> res and flags stable, in_ready=0, new in_valid not accepted. Release -> IDLE next cycle.
- Assert reset during cycle 4 of a MUL -> out_valid=0 immediately. After release, an ADD 1+1 -> 2 with correct latency.
- Illegal opcode 4'hF -> err=1, res=0. Following EQL x=y=8'h5A -> res=1, f_eq=1, err=0.
